// File: rtl/fpu_pack_arbiter.sv
// fpu_pack_arbiter
// Round-robin arbiter in front of a shared floating-point pack stage. The
// winning lane's {sign, exponent, significand} is packed into IEEE-style
// layout by dropping the implied bit. The result and its lane ID are held in
// a one-entry output register.
//
// Optional feature: define FPU_PACK_ARB_HIDDEN_CHECK_EN to register an
// implied-bit consistency flag on out_err. Otherwise out_err is tied 0.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   per-lane handshake (ready is one-hot or zero)
//   req_sign          sign per lane
//   req_exponent      lane i at [i*EXPONENT_WIDTH +: EXPONENT_WIDTH]
//   req_significand   lane i at [i*(SIGNIFICAND_WIDTH+1) +: SIGNIFICAND_WIDTH+1]
//   out_valid/ready   result handshake
//   out_packed        {sign, exponent, fraction}
//   out_id            lane that produced out_packed
//   out_err           implied-bit inconsistency flag
module fpu_pack_arbiter #(
    parameter int unsigned EXPONENT_WIDTH    = 11,
    parameter int unsigned SIGNIFICAND_WIDTH = 52,
    parameter int unsigned NUM_REQ           = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [NUM_REQ-1:0]                           req_valid,
    output logic [NUM_REQ-1:0]                           req_ready,
    input  logic [NUM_REQ-1:0]                           req_sign,
    input  logic [NUM_REQ*EXPONENT_WIDTH-1:0]            req_exponent,
    input  logic [NUM_REQ*(SIGNIFICAND_WIDTH+1)-1:0]     req_significand,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [EXPONENT_WIDTH+SIGNIFICAND_WIDTH:0]    out_packed,
    output logic [$clog2(NUM_REQ)-1:0]                   out_id,
    output logic                                         out_err
);

    localparam int unsigned ID_W   = $clog2(NUM_REQ);
    localparam int unsigned MANT_W = SIGNIFICAND_WIDTH + 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                          state;
    logic   [ID_W-1:0]               rr_ptr;
    logic   [ID_W-1:0]               win;
    logic   [ID_W-1:0]               nxt_ptr;
    logic                            found;
    logic                            can_accept;
    logic                            xfer;
    logic                            sel_sign;
    logic   [EXPONENT_WIDTH-1:0]     sel_exp;
    logic   [SIGNIFICAND_WIDTH-1:0]  sel_frac;
    logic                            sel_hid;

    // First valid lane at or above rr_ptr, wrapping at NUM_REQ.
    always_comb begin : p_arb
        int unsigned sum;
        found = 1'b0;
        win   = '0;
        sum   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = 32'(rr_ptr) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            if (!found && req_valid[ID_W'(sum)]) begin
                found = 1'b1;
                win   = ID_W'(sum);
            end
        end
    end

    // Operand mux for the winning lane.
    always_comb begin
        sel_sign = 1'b0;
        sel_exp  = '0;
        sel_frac = '0;
        sel_hid  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == win) begin
                sel_sign = req_sign[i];
                sel_exp  = req_exponent[i*EXPONENT_WIDTH +: EXPONENT_WIDTH];
                sel_frac = req_significand[i*MANT_W +: SIGNIFICAND_WIDTH];
                sel_hid  = req_significand[i*MANT_W + SIGNIFICAND_WIDTH];
            end
        end
    end

    // Explicit wrap so non-power-of-two lane counts rotate correctly.
    assign nxt_ptr    = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
    assign can_accept = (state == EMPTY) || out_ready;
    assign xfer       = rst_n && can_accept && found;
    assign out_valid  = (state == FULL);

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[win] = 1'b1;
        end
    end

    // Output register; a transfer always wins over a drain (refill in place).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_packed <= '0;
            out_id     <= '0;
            rr_ptr     <= '0;
        end else if (xfer) begin
            state      <= FULL;
            out_packed <= {sel_sign, sel_exp, sel_frac};
            out_id     <= win;
            rr_ptr     <= nxt_ptr;
        end else if (out_ready) begin
            state      <= EMPTY;
        end
    end

`ifdef FPU_PACK_ARB_HIDDEN_CHECK_EN
    // Zero exponent must carry implied bit 0, non-zero exponent implied bit 1.
    logic sel_err;
    assign sel_err = ((sel_exp == '0) && sel_hid) || ((sel_exp != '0) && !sel_hid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_err <= 1'b0;
        end else if (xfer) begin
            out_err <= sel_err;
        end
    end
`else
    logic unused_hid;
    assign unused_hid = sel_hid;
    assign out_err    = 1'b0;
`endif

endmodule
